vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- H_ACTIVE 640: visible pixels per line
- H_FP 16: horizontal front porch, pixels
- H_SYNC 96: horizontal sync width, pixels
- H_BP 48: horizontal back porch, pixels
- V_ACTIVE 480: visible lines per frame
- V_FP 10: vertical front porch, lines
- V_SYNC 2: vertical sync width, lines
- V_BP 33: vertical back porch, lines
- H_SYNC_POL 0: hSync active level (0 = active-low)
- V_SYNC_POL 0: vSync active level (0 = active-low)
- PIX_DIV 2: system clocks per pixel, 1..16
REQ-002 Derived values: H_TOTAL = sum of the four H_* values; V_TOTAL = sum of the four V_* values; HW = $clog2(H_TOTAL); VW = $clog2(V_TOTAL).
REQ-003 Ports (name, direction, width, meaning) SHALL be:
- clk, in, 1: system clock
- rst_n, in, 1: asynchronous active-low reset
- enable, in, 1: run timing; low freezes all state
- pix_ce, out, 1: one-clk strobe marking new pixel values
- hCount, out, HW: horizontal position 0..H_TOTAL-1
- vCount, out, VW: vertical position 0..V_TOTAL-1
- hSync, out, 1: horizontal sync at H_SYNC_POL
- vSync, out, 1: vertical sync at V_SYNC_POL
- de, out, 1: display enable, pixel inside active area
- line_start, out, 1: one-clk strobe at hCount==0
- frame_start, out, 1: one-clk strobe at (0,0)

Function
REQ-004 A divider counter div SHALL count 0..PIX_DIV-1 while enable=1 and wrap to 0; a "tick" is a cycle with enable=1 and div==PIX_DIV-1.
REQ-005 On each tick, hCount SHALL increment; at H_TOTAL-1 it SHALL wrap to 0 and vCount SHALL increment; vCount at V_TOTAL-1 with an hCount wrap SHALL wrap to 0.
REQ-006 All outputs SHALL be registered and updated on the tick edge from the next counter values, so syncs, de and strobes always match hCount/vCount in the same cycle (zero relative skew).
REQ-007 hSync SHALL equal H_SYNC_POL when H_ACTIVE+H_FP <= hCount < H_ACTIVE+H_FP+H_SYNC, else its inverse; vSync likewise, using vCount and the V_* values.
REQ-008 de SHALL be 1 if and only if hCount < H_ACTIVE and vCount < V_ACTIVE.
REQ-009 pix_ce, line_start and frame_start SHALL be high for exactly the one clk following a tick; line_start additionally requires hCount==0, frame_start requires hCount==0 and vCount==0.
REQ-010 PIX_DIV=1 SHALL make pix_ce continuously high while enable=1.
REQ-011 With enable=0, div, counters and levels SHALL hold, and pix_ce/line_start/frame_start SHALL be 0; resuming continues from the held div value.
REQ-012 Illegal parameters (any zero width, PIX_DIV outside 1..16) SHALL be rejected at elaboration.

Reset
REQ-013 rst_n low SHALL asynchronously set div=0, hCount=H_TOTAL-1, vCount=V_TOTAL-1, hSync=~H_SYNC_POL, vSync=~V_SYNC_POL, de=0, and all strobes=0.
REQ-014 After rst_n deasserts, the first tick SHALL produce (0,0) with frame_start=1 and de=1.
REQ-015 Reset asserted mid-frame SHALL take effect without waiting for a clock edge.

Structure
REQ-016 Package vga_timing_pkg SHALL hold the 640x480@60 default constants and a timing struct type (active, fp, sync, bp).
REQ-017 Per-axis logic SHALL be one sub-module, vga_axis_counter (count, wrap, sync, active decode), instantiated once per axis; the top level holds the divider and strobes.

Verification
REQ-018 Default parameters, rst_n released: first tick at clk 2 -> hCount=0, vCount=0, frame_start=1, line_start=1, de=1.
REQ-019 hCount 655->656 -> hSync falls; hCount 751->752 -> hSync rises; sync low for 192 clk.
REQ-020 vSync is low only for vCount 490..491; frame_start period is 840000 clk.
REQ-021 enable=0 for 50 clk at hCount=100 -> counters hold at 100, no strobes, and 101 is reached on the first tick after resume.
REQ-022 Override H=8/1/2/1, V=4/1/1/1, SYNC_POL=1, PIX_DIV=1 -> active-high hSync at hCount 9..10, and the counters wrap at 11 and 6.
REQ-023 rst_n pulsed low at (300,200) -> outputs reach reset values immediately, and (0,0) with frame_start=1 occurs on the first tick after release.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 default timing constants and the per-axis timing type.
package vga_timing_pkg;

    typedef struct packed {
        logic [15:0] active;
        logic [15:0] fp;
        logic [15:0] sync;
        logic [15:0] bp;
    } timing_t;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam timing_t DEF_H = '{16'd640, 16'd16, 16'd96, 16'd48};
    localparam timing_t DEF_V = '{16'd480, 16'd10, 16'd2, 16'd33};

    function automatic int axis_total(timing_t t);
        return int'(t.active) + int'(t.fp) + int'(t.sync) + int'(t.bp);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one timing axis -- position counter with wrap, sync decode and
// look-ahead active decode so the top can register de alongside the count.
module vga_axis_counter import vga_timing_pkg::*; #(
    parameter timing_t T   = DEF_H,
    parameter logic    POL = 1'b0,
    parameter int      W   = $clog2(axis_total(T))
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_i,
    output logic [W-1:0] count_o,
    output logic         last_o,
    output logic         sync_o,
    output logic         act_d_o
);
    localparam int TOT = axis_total(T);
    localparam int S0  = int'(T.active) + int'(T.fp);
    localparam int S1  = S0 + int'(T.sync);

    logic [W-1:0] count_q, count_d;
    logic         sync_q, sync_d;

    assign last_o = count_q == W'(TOT - 1);

    // Sync and active are decoded from the next count so they land with it.
    always_comb begin
        count_d = inc_i ? (last_o ? '0 : count_q + 1'b1) : count_q;
        sync_d  = (count_d >= W'(S0) && count_d < W'(S1)) ? POL : ~POL;
        act_d_o = count_d < W'(T.active);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= W'(TOT - 1);
            sync_q  <= ~POL;
        end else begin
            count_q <= count_d;
            sync_q  <= sync_d;
        end
    end

    assign count_o = count_q;
    assign sync_o  = sync_q;

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: pixel-clock divider plus horizontal/vertical axis counters producing
// registered, zero-skew VGA sync, display-enable and start strobes.
module vga_timing_gen import vga_timing_pkg::*; #(
    parameter int   H_ACTIVE   = DEF_H_ACTIVE,
    parameter int   H_FP       = DEF_H_FP,
    parameter int   H_SYNC     = DEF_H_SYNC,
    parameter int   H_BP       = DEF_H_BP,
    parameter int   V_ACTIVE   = DEF_V_ACTIVE,
    parameter int   V_FP       = DEF_V_FP,
    parameter int   V_SYNC     = DEF_V_SYNC,
    parameter int   V_BP       = DEF_V_BP,
    parameter logic H_SYNC_POL = 1'b0,
    parameter logic V_SYNC_POL = 1'b0,
    parameter int   PIX_DIV    = 2,
    localparam int  H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int  V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int  HW         = $clog2(H_TOTAL),
    localparam int  VW         = $clog2(V_TOTAL)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enable,
    output logic          pix_ce,
    output logic [HW-1:0] hCount,
    output logic [VW-1:0] vCount,
    output logic          hSync,
    output logic          vSync,
    output logic          de,
    output logic          line_start,
    output logic          frame_start
);
    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
        PIX_DIV < 1 || PIX_DIV > 16) begin : g_bad_params
        $error("vga_timing_gen: illegal timing parameters");
    end

    localparam timing_t HT = '{16'(H_ACTIVE), 16'(H_FP), 16'(H_SYNC), 16'(H_BP)};
    localparam timing_t VT = '{16'(V_ACTIVE), 16'(V_FP), 16'(V_SYNC), 16'(V_BP)};

    logic [3:0] div_q, div_d;
    logic       tick, h_last, v_last, h_act_d, v_act_d;
    logic       pix_ce_q, line_start_q, frame_start_q, de_q;

    assign tick  = enable && div_q == 4'(PIX_DIV - 1);
    assign div_d = tick ? '0 : (enable ? div_q + 4'd1 : div_q);

    vga_axis_counter #(.T(HT), .POL(H_SYNC_POL), .W(HW)) u_h (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (tick),
        .count_o (hCount),
        .last_o  (h_last),
        .sync_o  (hSync),
        .act_d_o (h_act_d)
    );

    vga_axis_counter #(.T(VT), .POL(V_SYNC_POL), .W(VW)) u_v (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (tick && h_last),
        .count_o (vCount),
        .last_o  (v_last),
        .sync_o  (vSync),
        .act_d_o (v_act_d)
    );

    // A wrapping counter means the next position on that axis is 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q         <= '0;
            pix_ce_q      <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            de_q          <= 1'b0;
        end else begin
            div_q         <= div_d;
            pix_ce_q      <= tick;
            line_start_q  <= tick && h_last;
            frame_start_q <= tick && h_last && v_last;
            de_q          <= tick ? (h_act_d && v_act_d) : de_q;
        end
    end

    assign pix_ce      = pix_ce_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign de          = de_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: three generator configurations under random enable against an
// arithmetic model that derives the screen position from the count of enabled cycles.
module tb_vga_timing_gen;

    localparam int  HA[3] = '{640, 8, 20};
    localparam int  HF[3] = '{16, 1, 2};
    localparam int  HS[3] = '{96, 2, 3};
    localparam int  HB[3] = '{48, 1, 2};
    localparam int  VA[3] = '{480, 4, 10};
    localparam int  VF[3] = '{10, 1, 2};
    localparam int  VS[3] = '{2, 1, 2};
    localparam int  VB[3] = '{33, 1, 3};
    localparam bit  HP[3] = '{1'b0, 1'b1, 1'b0};
    localparam bit  VP[3] = '{1'b0, 1'b1, 1'b0};
    localparam int  PD[3] = '{2, 1, 3};

    logic clk = 1'b0;
    logic rst_a, rst_b, rst_c, en_a, en_b, en_c;
    logic [9:0] hc_a, vc_a;
    logic [3:0] hc_b;
    logic [2:0] vc_b;
    logic [4:0] hc_c, vc_c;
    logic pce_a, hs_a, vs_a, de_a, ls_a, fs_a;
    logic pce_b, hs_b, vs_b, de_b, ls_b, fs_b;
    logic pce_c, hs_c, vs_c, de_c, ls_c, fs_c;
    int   n_chk = 0, n_err = 0;
    bit   done = 0, found;

    always #5 clk = ~clk;

    vga_timing_gen u_a (
        .clk(clk), .rst_n(rst_a), .enable(en_a), .pix_ce(pce_a), .hCount(hc_a), .vCount(vc_a),
        .hSync(hs_a), .vSync(vs_a), .de(de_a), .line_start(ls_a), .frame_start(fs_a)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1), .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .PIX_DIV(1)
    ) u_b (
        .clk(clk), .rst_n(rst_b), .enable(en_b), .pix_ce(pce_b), .hCount(hc_b), .vCount(vc_b),
        .hSync(hs_b), .vSync(vs_b), .de(de_b), .line_start(ls_b), .frame_start(fs_b)
    );

    vga_timing_gen #(
        .H_ACTIVE(20), .H_FP(2), .H_SYNC(3), .H_BP(2), .V_ACTIVE(10), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .PIX_DIV(3)
    ) u_c (
        .clk(clk), .rst_n(rst_c), .enable(en_c), .pix_ce(pce_c), .hCount(hc_c), .vCount(vc_c),
        .hSync(hs_c), .vSync(vs_c), .de(de_c), .line_start(ls_c), .frame_start(fs_c)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: n enabled cycles since reset; every PD-th one is a tick.
    int na, nb, nc;
    bit ta, tb_, tc;
    always @(posedge clk or negedge rst_a)
        if (!rst_a) begin na <= 0; ta <= 0; end
        else begin ta <= en_a && (na % PD[0] == PD[0] - 1); na <= na + int'(en_a); end
    always @(posedge clk or negedge rst_b)
        if (!rst_b) begin nb <= 0; tb_ <= 0; end
        else begin tb_ <= en_b && (nb % PD[1] == PD[1] - 1); nb <= nb + int'(en_b); end
    always @(posedge clk or negedge rst_c)
        if (!rst_c) begin nc <= 0; tc <= 0; end
        else begin tc <= en_c && (nc % PD[2] == PD[2] - 1); nc <= nc + int'(en_c); end

    function automatic void model(input int i, input int n, input bit t,
                                  output int eh, output int ev,
                                  output bit ehs, output bit evs, output bit ede,
                                  output bit ece, output bit els, output bit efs);
        int ht = HA[i] + HF[i] + HS[i] + HB[i];
        int vt = VA[i] + VF[i] + VS[i] + VB[i];
        int p;
        if (n < PD[i]) begin
            eh = ht - 1; ev = vt - 1; ehs = !HP[i]; evs = !VP[i]; ede = 0;
        end else begin
            p   = n / PD[i] - 1;
            eh  = p % ht;
            ev  = (p / ht) % vt;
            ehs = (eh >= HA[i] + HF[i] && eh < HA[i] + HF[i] + HS[i]) ? HP[i] : !HP[i];
            evs = (ev >= VA[i] + VF[i] && ev < VA[i] + VF[i] + VS[i]) ? VP[i] : !VP[i];
            ede = eh < HA[i] && ev < VA[i];
        end
        ece = t;
        els = t && eh == 0;
        efs = els && ev == 0;
    endfunction

    int oh[3], ov[3], mn[3];
    bit ohs[3], ovs[3], ode[3], oce[3], ols[3], ofs[3], mt[3];
    always_comb begin
        oh[0] = int'(hc_a); ov[0] = int'(vc_a); oh[1] = int'(hc_b); ov[1] = int'(vc_b);
        oh[2] = int'(hc_c); ov[2] = int'(vc_c);
        ohs = '{hs_a, hs_b, hs_c}; ovs = '{vs_a, vs_b, vs_c}; ode = '{de_a, de_b, de_c};
        oce = '{pce_a, pce_b, pce_c}; ols = '{ls_a, ls_b, ls_c}; ofs = '{fs_a, fs_b, fs_c};
        mn = '{na, nb, nc}; mt = '{ta, tb_, tc};
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            int eh, ev;
            bit ehs, evs, ede, ece, els, efs;
            model(i, mn[i], mt[i], eh, ev, ehs, evs, ede, ece, els, efs);
            check($sformatf("hCount[%0d]", i), oh[i], eh);
            check($sformatf("vCount[%0d]", i), ov[i], ev);
            check($sformatf("hSync[%0d]", i), int'(ohs[i]), int'(ehs));
            check($sformatf("vSync[%0d]", i), int'(ovs[i]), int'(evs));
            check($sformatf("de[%0d]", i), int'(ode[i]), int'(ede));
            check($sformatf("pix_ce[%0d]", i), int'(oce[i]), int'(ece));
            check($sformatf("line_start[%0d]", i), int'(ols[i]), int'(els));
            check($sformatf("frame_start[%0d]", i), int'(ofs[i]), int'(efs));
        end
    end

    initial begin
        en_b = 0; en_c = 0; rst_b = 0; rst_c = 0;
        repeat (3) @(negedge clk);
        #1 rst_b = 1; rst_c = 1;
        for (int c = 0; !done; c++) begin
            @(negedge clk);
            #1 en_b = ($urandom % 5) != 0;
            en_c = ($urandom % 4) != 0;
            if (c == 4000) rst_c = 0;
            if (c == 4003) rst_c = 1;
        end
    end

    initial begin
        rst_a = 0; en_a = 0;
        repeat (3) @(negedge clk);
        #1 rst_a = 1; en_a = 1;
        found = 0;
        for (int c = 0; c < 2000 && !found; c++) begin
            @(negedge clk);
            found = hc_a == 10'd100 && pce_a;
        end
        check("wait_h100", int'(found), 1);
        #1 en_a = 0;
        repeat (50) @(negedge clk);
        #1 en_a = 1;
        repeat (3000) @(negedge clk);
        #1 rst_a = 0;
        #1;
        check("rst_async_h", int'(hc_a), 799);
        check("rst_async_v", int'(vc_a), 524);
        check("rst_async_hs", int'(hs_a), 1);
        check("rst_async_vs", int'(vs_a), 1);
        check("rst_async_de", int'(de_a), 0);
        check("rst_async_strobes", int'({pce_a, ls_a, fs_a}), 0);
        @(negedge clk);
        #1 rst_a = 1;
        repeat (12000) @(negedge clk);
        done = 1;
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
